add_n: RTL and testbench

- Parameterised N-bit binary adder with carry-in, carry-out and signed-overflow flag.
- All outputs are registered, giving one-cycle latency.
- Used as the arithmetic core of small datapath helpers, e.g. the times-five multiplier in the I/O read/write interface. That multiplier instantiates it with N=16 and operands (x<<2) and x, zero-extended, with c_in tied to 0.
- Fully pipelined: accepts a new operand pair every clock.

---
 rtl/add_n_if.sv | 24 ++
 rtl/add_n.sv | 59 +++++
 tb/tb_add_n.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/add_n_if.sv
// add_n_if: operand/result bundle for the add_n adder.
//   master: drives x, y, c_in; observes s, c_out, ovf.
//   slave : observes x, y, c_in; drives s, c_out, ovf.
// N must match the N of the add_n instance the interface is connected to.
interface add_n_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         c_in;
    logic [N-1:0] s;
    logic         c_out;
    logic         ovf;

    modport master (
        output x, y, c_in,
        input  s, c_out, ovf
    );

    modport slave (
        input  x, y, c_in,
        output s, c_out, ovf
    );
endinterface

// File: rtl/add_n.sv
// add_n: N-bit ripple-carry adder with carry-in, carry-out and signed-overflow
// flag. All outputs are registered: one cycle latency, one result per cycle.
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset, zeroes all outputs
//   bus.x     : first operand (N bits, unsigned or two's complement)
//   bus.y     : second operand (same encoding as x)
//   bus.c_in  : carry into bit 0
//   bus.s     : registered sum, (x + y + c_in) mod 2^N
//   bus.c_out : registered carry out of bit N-1
//   bus.ovf   : registered two's-complement overflow (carry_N ^ carry_(N-1))
module add_n #(
    parameter int unsigned N = 8
) (
    input  logic     clock,
    input  logic     reset,
    add_n_if.slave   bus
);

    logic [N-1:0] sum;
    logic         carry;     // running carry through the chain
    logic         carry_n;   // carry out of bit N-1
    logic         carry_nm1; // carry into bit N-1 (equals c_in when N == 1)

    logic [N-1:0] s_q;
    logic         c_out_q;
    logic         ovf_q;

    // Ripple chain of full-adder cells.
    always_comb begin
        sum       = '0;
        carry     = bus.c_in;
        carry_nm1 = bus.c_in;
        for (int unsigned i = 0; i < N; i++) begin
            carry_nm1 = carry;
            sum[i]    = bus.x[i] ^ bus.y[i] ^ carry;
            carry     = (bus.x[i] & bus.y[i]) | (carry & (bus.x[i] ^ bus.y[i]));
        end
        carry_n = carry;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s_q     <= sum;
            c_out_q <= carry_n;
            ovf_q   <= carry_n ^ carry_nm1;
        end
    end

    always_comb begin
        bus.s     = s_q;
        bus.c_out = c_out_q;
        bus.ovf   = ovf_q;
    end

endmodule

// File: tb/tb_add_n.sv
// tb_add_n: self-checking bench for add_n at N = 16, 8 and 1. All three
// instances share clock/reset and are checked every cycle against an
// arithmetic reference model; N = 16 additionally gets directed constants.
module tb_add_n;

    logic clock;
    logic reset;

    int errors;
    int checks;

    add_n_if #(.N(16)) if16 ();
    add_n_if #(.N(8))  if8  ();
    add_n_if #(.N(1))  if1  ();

    add_n #(.N(16)) dut16 (.clock(clock), .reset(reset), .bus(if16.slave));
    add_n #(.N(8))  dut8  (.clock(clock), .reset(reset), .bus(if8.slave));
    add_n #(.N(1))  dut1  (.clock(clock), .reset(reset), .bus(if1.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition, overflow from the signed value range.
    function automatic void ref_add(input int n, input longint unsigned a,
                                    input longint unsigned b, input bit ci,
                                    output longint unsigned sum, output bit co,
                                    output bit ov);
        longint unsigned tot;
        longint          sa;
        longint          sb;
        longint          st;
        longint          half;
        tot  = a + b + longint'(ci);
        sum  = tot & ((64'd1 << n) - 64'd1);
        co   = ((tot >> n) & 64'd1) != 0;
        half = longint'(1) << (n - 1);
        sa   = longint'(a);
        sb   = longint'(b);
        if (sa >= half) sa = sa - (half * 2);
        if (sb >= half) sb = sb - (half * 2);
        st   = sa + sb + longint'(ci);
        ov   = (st > half - 1) || (st < -half);
    endfunction

    // Capture current inputs, advance one edge, compare all instances.
    task automatic tick_check(input string tag);
        longint unsigned e_s16, e_s8, e_s1;
        bit e_c16, e_o16, e_c8, e_o8, e_c1, e_o1;
        ref_add(16, 64'(if16.x), 64'(if16.y), if16.c_in, e_s16, e_c16, e_o16);
        ref_add(8,  64'(if8.x),  64'(if8.y),  if8.c_in,  e_s8,  e_c8,  e_o8);
        ref_add(1,  64'(if1.x),  64'(if1.y),  if1.c_in,  e_s1,  e_c1,  e_o1);
        if (reset) begin
            e_s16 = 0; e_c16 = 0; e_o16 = 0;
            e_s8  = 0; e_c8  = 0; e_o8  = 0;
            e_s1  = 0; e_c1  = 0; e_o1  = 0;
        end
        @(posedge clock);
        #1;
        check({tag, "/s16"},  64'(if16.s),     e_s16);
        check({tag, "/co16"}, 64'(if16.c_out), 64'(e_c16));
        check({tag, "/ov16"}, 64'(if16.ovf),   64'(e_o16));
        check({tag, "/s8"},   64'(if8.s),      e_s8);
        check({tag, "/co8"},  64'(if8.c_out),  64'(e_c8));
        check({tag, "/ov8"},  64'(if8.ovf),    64'(e_o8));
        check({tag, "/s1"},   64'(if1.s),      e_s1);
        check({tag, "/co1"},  64'(if1.c_out),  64'(e_c1));
        check({tag, "/ov1"},  64'(if1.ovf),    64'(e_o1));
    endtask

    task automatic expect16(input string tag, input logic [15:0] s,
                            input logic co, input logic ov);
        check({tag, "/k_s16"},  64'(if16.s),     64'(s));
        check({tag, "/k_co16"}, 64'(if16.c_out), 64'(co));
        check({tag, "/k_ov16"}, 64'(if16.ovf),   64'(ov));
    endtask

    task automatic set16(input logic [15:0] a, input logic [15:0] b, input logic c);
        if16.x = a; if16.y = b; if16.c_in = c;
    endtask

    task automatic randomize_small();
        logic [31:0] r;
        r = $urandom;
        if8.x = r[7:0]; if8.y = r[15:8]; if8.c_in = r[16];
        if1.x = r[17:17]; if1.y = r[18:18]; if1.c_in = r[19];
    endtask

    initial begin
        logic [31:0] r;
        errors = 0;
        checks = 0;

        // Reset with live data on the inputs: data must be discarded.
        reset = 1'b1;
        set16(16'h1234, 16'h4321, 1'b1);
        if8.x = 8'hff; if8.y = 8'h01; if8.c_in = 1'b1;
        if1.x = 1'b1; if1.y = 1'b1; if1.c_in = 1'b1;
        tick_check("reset");
        expect16("reset", 16'h0000, 1'b0, 1'b0);

        // Times-five check: 5 * 0xFF.
        reset = 1'b0;
        set16(16'h03fc, 16'h00ff, 1'b0);
        randomize_small();
        tick_check("x5");
        expect16("x5", 16'h04fb, 1'b0, 1'b0);

        set16(16'hffff, 16'h0001, 1'b0);
        tick_check("wrap_a");
        expect16("wrap_a", 16'h0000, 1'b1, 1'b0);

        set16(16'hffff, 16'h0000, 1'b1);
        tick_check("wrap_cin");
        expect16("wrap_cin", 16'h0000, 1'b1, 1'b0);

        set16(16'h7fff, 16'h0001, 1'b0);
        tick_check("ovf_pos");
        expect16("ovf_pos", 16'h8000, 1'b0, 1'b1);

        set16(16'h8000, 16'h8000, 1'b0);
        tick_check("ovf_neg");
        expect16("ovf_neg", 16'h0000, 1'b1, 1'b1);

        // Back-to-back stream on consecutive edges.
        set16(16'd1, 16'd2, 1'b0);
        tick_check("b2b0");
        expect16("b2b0", 16'd3, 1'b0, 1'b0);
        set16(16'd3, 16'd4, 1'b0);
        tick_check("b2b1");
        expect16("b2b1", 16'd7, 1'b0, 1'b0);
        set16(16'h00ff, 16'h0001, 1'b0);
        tick_check("b2b2");
        expect16("b2b2", 16'h0100, 1'b0, 1'b0);

        // Reset mid-stream.
        set16(16'h8005, 16'h8006, 1'b0);
        tick_check("pre_rst");
        expect16("pre_rst", 16'h000b, 1'b1, 1'b1);
        reset = 1'b1;
        set16(16'h0007, 16'h0008, 1'b1);
        tick_check("mid_rst");
        expect16("mid_rst", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        set16(16'h0009, 16'h0001, 1'b0);
        tick_check("post_rst");
        expect16("post_rst", 16'h000a, 1'b0, 1'b0);

        // Times-five connection sweep.
        for (int i = 0; i < 256; i++) begin
            set16(16'(i), 16'(i) << 2, 1'b0);
            randomize_small();
            tick_check("sweep");
            check("sweep/x5", 64'(if16.s), 64'(5 * i));
            check("sweep/co0", 64'(if16.c_out), 64'd0);
        end

        // Exhaustive N=1 combinations.
        for (int i = 0; i < 8; i++) begin
            r = 32'(i);
            if1.x = r[0:0]; if1.y = r[1:1]; if1.c_in = r[2];
            tick_check("n1_exh");
        end

        // Random compare at all widths.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            set16(r[15:0], r[31:16], r[0] ^ r[31]);
            randomize_small();
            tick_check("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
